pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, carry-pipelined adder/subtractor that splits a WIDTH-bit operation into STAGES equal segments. Each segment is resolved in its own clock cycle, and the carry is registered between segments. It accepts one operation per cycle under a valid/ready handshake with full backpressure. It replaces the purely combinational ripple path in datapaths where WIDTH is too wide to close timing in one cycle.

## Interface
- WIDTH, 32, operand width in bits; must be an integer multiple of STAGES.
- STAGES, 4, number of pipeline segments (1..WIDTH); SEG = WIDTH/STAGES bits per segment.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  input operation present.
- o_ready  out  1  block can accept input this cycle.
- i_add1  in  WIDTH  operand A, unsigned/two's complement.
- i_add2  in  WIDTH  operand B.
- i_sub  in  1  0: A+B+i_cin; 1: A-B (i_cin ignored).
- i_cin  in  1  carry-in for add mode.
- o_valid  out  1  o_result valid.
- i_ready  in  1  downstream accepts o_result.
- o_result  out  WIDTH+1  sum/difference; bit WIDTH = carry-out (add) or borrow (sub).
- o_ovf  out  1  signed overflow (only with macro, else tied 0).

## Operation
- Transfer in: i_valid && o_ready. Transfer out: o_valid && i_ready.
- Sub mode: B inverted, segment-0 carry-in forced 1; o_result[WIDTH] = ~carry_out (1 = A<B unsigned).
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of A and B' plus the registered carry from stage k-1, producing a SEG-bit partial sum and a carry into stage k+1's register.
- Operand slices for stage k are delayed k cycles in skew registers. Partial sums from stage k are delayed STAGES-1-k cycles in de-skew registers, so the whole word emerges aligned.
- Per-stage valid bit travels with data; bubbles (i_valid=0) propagate as invalid slots.
- Global advance enable: adv = ~o_valid | i_ready. o_ready = adv. When adv=0, every data/valid/carry register holds.
- No state machine beyond per-stage valid shift; no internal reordering.

## Timing
- Latency: STAGES cycles from input transfer to o_valid (STAGES=1: result registered once, 1 cycle).
- Throughput: 1 op/cycle when i_ready held high.
- Reset (async assert, sync-to-clock deassert by upstream): all valids 0 → o_valid=0, o_result=0, o_ovf=0, o_ready=1 in reset.
- Reset mid-operation: all in-flight ops discarded, no partial output.
- Stall: o_result/o_valid stable while o_valid && ~i_ready; o_ready combinationally drops same cycle.
- Simultaneous output transfer and input transfer in a full pipeline: both occur, no bubble inserted.
- o_ready depends combinationally on i_ready (no skid buffer); upstream must not gate i_valid on o_ready.

## Configuration
- PIPELINED_ADDER_OVF_EN defined: o_ovf = signed overflow of final segment (carry into MSB XOR carry out), aligned with o_result and held on stall.
- Undefined: o_ovf driven constant 0, no extra flop/logic.

## Structure
- Shared package/include: mode encoding constants (ADD=0, SUB=1), WIDTH%STAGES legality check macro, default WIDTH/STAGES.
- One sub-module: adder_segment (SEG-bit combinational adder, inputs a, b, cin; outputs sum, cout), instantiated STAGES times via generate; stage/skew registers live in pipelined_adder.

## Test plan
- WIDTH=32, STAGES=4, add 0xFFFFFFFF + 0x00000001, cin=0 → after 4 cycles o_result=0x1_00000000, o_ovf=0.
- Sub 0x00000005 - 0x00000007 → o_result=0x1_FFFFFFFE (borrow=1); sub 7-5 → 0x0_00000002.
- Add 0x7FFFFFFF + 1 (macro on) → o_result=0x0_80000000, o_ovf=1; macro off → o_ovf=0.
- Back-to-back 8 ops with i_ready=1 → 8 results on consecutive cycles in order, first at cycle 4.
- Hold i_ready=0 for 3 cycles with pipeline full → o_result unchanged, o_ready=0, no op lost or duplicated after release.
- Assert i_rst with 3 ops in flight → o_valid=0 immediately; after release, new op 2+3 yields 5 after 4 cycles, stale ops never appear.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the carry-pipelined adder/subtractor: mode encoding,
// default geometry and the WIDTH/STAGES split legality check.
`define PIPELINED_ADDER_LEGAL(w, s) (((s) >= 1) && ((s) <= (w)) && (((w) % (s)) == 0))

package pipelined_adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

endpackage

// File: rtl/adder_segment.sv
// SEG-bit combinational ripple segment; one instance resolves one pipeline
// stage's slice of the full-width add.
module adder_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined WIDTH-bit adder/subtractor resolved over STAGES cycles.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_sub,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_ovf
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (!`PIPELINED_ADDER_LEGAL(WIDTH, STAGES)) begin : g_bad_split
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Handshake: a beat moves in on i_valid && o_ready and out on
    // o_valid && i_ready. The whole pipe advances as one (adv); when the
    // output is valid and not taken, every stage holds and o_ready drops in
    // the same cycle. Upstream must hold i_valid and data until accepted.
    logic adv;

    // Stage k registers carry full-width operand/sum words; only the
    // segments still pending (operands) or already resolved (sums) are live.
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q;
    logic [STAGES-1:0]            c_q;
    logic [STAGES-1:0]            v_q;
    logic [STAGES-1:0]            sub_q;

    logic [STAGES-1:0][SEG-1:0] seg_a;
    logic [STAGES-1:0][SEG-1:0] seg_b;
    logic [STAGES-1:0][SEG-1:0] seg_sum;
    logic [STAGES-1:0]          seg_cin;
    logic [STAGES-1:0]          seg_cout;

    mode_e            mode;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign mode    = mode_e'(i_sub);
    assign b_eff   = (mode == MODE_SUB) ? ~i_add2 : i_add2;
    assign cin_eff = (mode == MODE_SUB) ? 1'b1 : i_cin;

    assign o_valid = v_q[LAST];
    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;

    // Subtraction reports borrow, the complement of the final carry.
    assign o_result = {c_q[LAST] ^ sub_q[LAST], s_q[LAST]};

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign seg_a[k]   = i_add1[SEG-1:0];
            assign seg_b[k]   = b_eff[SEG-1:0];
            assign seg_cin[k] = cin_eff;
        end else begin : g_rest
            assign seg_a[k]   = a_q[k-1][k*SEG +: SEG];
            assign seg_b[k]   = b_q[k-1][k*SEG +: SEG];
            assign seg_cin[k] = c_q[k-1];
        end

        adder_segment #(.SEG(SEG)) u_seg (
            .a    (seg_a[k]),
            .b    (seg_b[k]),
            .cin  (seg_cin[k]),
            .sum  (seg_sum[k]),
            .cout (seg_cout[k])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            v_q   <= '0;
            sub_q <= '0;
        end else if (adv) begin
            a_q[0]           <= i_add1;
            b_q[0]           <= b_eff;
            s_q[0]           <= '0;
            s_q[0][SEG-1:0]  <= seg_sum[0];
            c_q[0]           <= seg_cout[0];
            v_q[0]           <= i_valid;
            sub_q[0]         <= i_sub;
            for (int k = 1; k < STAGES; k++) begin
                a_q[k]               <= a_q[k-1];
                b_q[k]               <= b_q[k-1];
                s_q[k]               <= s_q[k-1];
                s_q[k][k*SEG +: SEG] <= seg_sum[k];
                c_q[k]               <= seg_cout[k];
                v_q[k]               <= v_q[k-1];
                sub_q[k]             <= sub_q[k-1];
            end
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // Carry into the MSB is recovered from a ^ b ^ sum at the top bit.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = seg_a[LAST][SEG-1] ^ seg_b[LAST][SEG-1]
                 ^ seg_sum[LAST][SEG-1] ^ seg_cout[LAST];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

    // Already-consumed operand slices are intentionally left dangling.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a_q, b_q};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=32, STAGES=4): vector table,
// streaming with backpressure, and reset with operations in flight.
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int NV     = 12;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [32:0] res;
        logic        ovf;
        string       name;
    } vec_t;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [WIDTH-1:0] i_add1 = '0;
    logic [WIDTH-1:0] i_add2 = '0;
    logic             i_sub = 1'b0;
    logic             i_cin = 1'b0;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [WIDTH:0]   o_result;
    logic             o_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[NV];
    logic [33:0] exp_q[$];

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_add1   (i_add1),
        .i_add2   (i_add2),
        .i_sub    (i_sub),
        .i_cin    (i_cin),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_ovf    (o_ovf)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- helpers ----------------
    function automatic logic exp_ovf(input logic ovf);
`ifdef PIPELINED_ADDER_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        i_add1  = v.a;
        i_add2  = v.b;
        i_sub   = v.sub;
        i_cin   = v.cin;
        i_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // One isolated operation: accepted at once, result after STAGES edges.
    task automatic run_single(input vec_t v);
        int lat;
        drive_op(v);
        i_ready = 1'b1;
        @(negedge i_clk);
        check({v.name, "/accept"}, 64'(o_ready), 64'd1);
        step();
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 12) begin
            step();
            lat++;
        end
        check({v.name, "/latency"}, 64'(lat), 64'(STAGES));
        check({v.name, "/result"}, 64'(o_result), 64'(v.res));
        check({v.name, "/ovf"}, 64'(o_ovf), 64'(exp_ovf(v.ovf)));
    endtask

    // Stream n table vectors back to back; i_ready is low for stall_len
    // cycles starting at cycle stall_at.
    task automatic run_stream(input string tag, input int start, input int n,
                              input int stall_at, input int stall_len);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        logic [32:0] held = '0;
        logic [33:0] e;
        vec_t cur;
        exp_q.delete();
        while (got < n && cyc < 200) begin
            i_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (sent < n) begin
                cur = vecs[(start + sent) % NV];
                drive_op(cur);
            end else begin
                i_valid = 1'b0;
            end
            @(negedge i_clk);
            if (!i_ready) begin
                check({tag, "/stall_ready"}, 64'(o_ready), 64'd0);
                if (cyc == stall_at) held = o_result;
                else check({tag, "/stall_hold"}, 64'(o_result), 64'(held));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s/extra_output: got 0x%0h, expected no output", tag, o_result);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s/result%0d", tag, got), 64'(o_result), 64'(e[32:0]));
                    check($sformatf("%s/ovf%0d", tag, got), 64'(o_ovf), 64'(e[33]));
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back({exp_ovf(cur.ovf), cur.res});
                sent++;
            end
            step();
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check({tag, "/count"}, 64'(got), 64'(n));
        check({tag, "/first_cycle"}, 64'(first), 64'(STAGES));
        check({tag, "/last_cycle"}, 64'(last), 64'(STAGES + n - 1 + stall_len));
        check({tag, "/leftover"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- main ----------------
    initial begin
        vec_t v;
        int spurious;

        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0, "add_wrap"};
        vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 33'h1_FFFF_FFFE, 1'b0, "sub_borrow"};
        vecs[2]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 33'h0_0000_0002, 1'b0, "sub_pos"};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_8000_0000, 1'b1, "add_ovf"};
        vecs[4]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 33'h0_ACF1_3569, 1'b0, "add_cin"};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 33'h0_7FFF_FFFF, 1'b1, "sub_ovf"};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 33'h0_0000_0000, 1'b0, "sub_zero"};
        vecs[7]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 33'h0_0001_0001, 1'b0, "add_chain"};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 33'h1_FFFF_FFFF, 1'b0, "add_allones"};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33'h1_0000_0000, 1'b1, "add_negovf"};
        vecs[10] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 33'h0_0000_0007, 1'b0, "sub_cin_ignored"};
        vecs[11] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 33'h0_0100_0100, 1'b0, "add_segcarry"};

        // Reset state
        step();
        step();
        @(negedge i_clk);
        check("reset/o_valid", 64'(o_valid), 64'd0);
        check("reset/o_result", 64'(o_result), 64'd0);
        check("reset/o_ovf", 64'(o_ovf), 64'd0);
        check("reset/o_ready", 64'(o_ready), 64'd1);
        step();
        i_rst = 1'b0;
        step();

        // Isolated vectors
        for (int i = 0; i < NV; i++) run_single(vecs[i]);
        step();

        // Back-to-back, then with a 3-cycle stall on a full pipe
        run_stream("stream8", 0, 8, 1000, 0);
        step();
        step();
        run_stream("stall8", 4, 8, 5, 3);
        step();
        step();

        // Reset with operations in flight
        for (int i = 0; i < STAGES; i++) begin
            drive_op(vecs[i]);
            i_ready = 1'b0;
            step();
        end
        i_valid = 1'b0;
        check("midrst/pre_valid", 64'(o_valid), 64'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check("midrst/o_valid", 64'(o_valid), 64'd0);
        check("midrst/o_result", 64'(o_result), 64'd0);
        check("midrst/o_ready", 64'(o_ready), 64'd1);
        step();
        i_rst   = 1'b0;
        i_ready = 1'b1;
        step();
        v = '{32'd2, 32'd3, 1'b0, 1'b0, 33'd5, 1'b0, "post_reset"};
        run_single(v);
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_valid) spurious++;
        end
        check("midrst/stale_outputs", 64'(spurious), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
